vga_pixel_scaler: RTL and testbench

//  Parametrised VGA pixel fetch stage between the VGA timing generator and the frame-buffer read port.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_pixel_scaler_if.sv | 11 +
 rtl/pixel_unpack.sv | 24 ++
 rtl/vga_pixel_scaler.sv | 202 ++++++++++++++++++++
 tb/tb_vga_pixel_scaler.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types for the VGA pixel fetch stage: pixel formats, RGB triple, pipeline tag.
package vga_pkg;

   typedef enum logic [1:0] {
      GRAY8  = 2'd0,
      RGB888 = 2'd1,
      RGB565 = 2'd2,
      RSVD   = 2'd3
   } pix_fmt_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Side information that travels alongside a read until its data returns
   typedef struct packed {
      logic     valid;
      logic     inwin;
      pix_fmt_e fmt;
   } pix_tag_t;

   localparam int SCREEN_W_DEF = 640;
   localparam int SCREEN_H_DEF = 480;

endpackage

// File: rtl/vga_pixel_scaler_if.sv
// Frame-buffer read port: registered address/strobe out, data back after a fixed latency.
interface vga_pixel_scaler_if #(
   parameter int ADDR_W = 22
);
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;
   logic [31:0]       rd_data;

   modport master (output rd_addr, output rd_en, input rd_data);
   modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/pixel_unpack.sv
// Combinational unpack of one frame-buffer word into 8-bit RGB.
module pixel_unpack
   import vga_pkg::*;
(
   input  pix_fmt_e    fmt,
   input  logic [31:0] data,
   output rgb_t        rgb
);
   logic unused_hi;
   assign unused_hi = ^data[31:24];

   always_comb begin
      rgb = '0;
      case (fmt)
         GRAY8:   rgb = '{r: data[7:0], g: data[7:0], b: data[7:0]};
         RGB888:  rgb = '{r: data[23:16], g: data[15:8], b: data[7:0]};
         // 565 widened by replicating the top bits into the vacated LSBs
         RGB565:  rgb = '{r: {data[15:11], data[15:13]},
                          g: {data[10:5],  data[10:9]},
                          b: {data[4:0],   data[4:2]}};
         default: rgb = '0;
      endcase
   end
endmodule

// File: rtl/vga_pixel_scaler.sv
// Pixel fetch stage: maps VGA position to a frame-buffer address (stretch or native centred),
// issues the read and unpacks the returned word. Fixed latency RD_LAT+2 from h/v to VGA_*.
//
// state         | meaning
// ST_WAIT_FRAME | counters untrusted (reset or sequence fault); reads and video held off until h=0,v=0
// ST_RUN        | locked to the timing generator; active pixels are fetched and displayed
module vga_pixel_scaler
   import vga_pkg::*;
#(
   parameter int IMG_W     = 300,
   parameter int IMG_H     = 300,
   parameter int SCREEN_W  = SCREEN_W_DEF,
   parameter int SCREEN_H  = SCREEN_H_DEF,
   parameter int ADDR_W    = 22,
   parameter int BASE_ADDR = 0,
   parameter int RD_LAT    = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [9:0]          h_counter,
   input  logic [9:0]          v_counter,
   input  logic                video_on,
   input  logic [1:0]          fmt,
   input  logic                native,
   input  logic [23:0]         border_rgb,
   vga_pixel_scaler_if.master  fb,
   output logic [7:0]          VGA_R,
   output logic [7:0]          VGA_G,
   output logic [7:0]          VGA_B,
   output logic                pix_valid,
   output logic                seq_err
);
   typedef logic [ADDR_W-1:0] addr_t;
   typedef enum logic {ST_WAIT_FRAME, ST_RUN} state_e;

   localparam int X0 = (SCREEN_W - IMG_W) / 2;
   localparam int Y0 = (SCREEN_H - IMG_H) / 2;

   localparam logic [9:0]  H_LAST = 10'(SCREEN_W - 1);
   localparam logic [9:0]  X_LO   = 10'(X0);
   localparam logic [9:0]  X_HI   = 10'(X0 + IMG_W);
   localparam logic [9:0]  Y_LO   = 10'(Y0);
   localparam logic [9:0]  Y_HI   = 10'(Y0 + IMG_H);
   localparam logic [15:0] SW_R   = 16'(SCREEN_W);
   localparam logic [15:0] SH_R   = 16'(SCREEN_H);
   localparam logic [15:0] IW_R   = 16'(IMG_W);
   localparam logic [15:0] IH_R   = 16'(IMG_H);
   localparam addr_t       IW_A   = addr_t'(IMG_W);
   localparam addr_t       BASE_A = addr_t'(BASE_ADDR);

   state_e      state, state_nxt;
   logic        run;
   logic        frame_start, seq_bad, active;
   logic [9:0]  prev_h, prev_v;
   logic        have_prev;

   pix_fmt_e    fmt_sh, fmt_cur;
   logic        native_sh, native_cur;
   logic        h_in_win, v_in_win, in_win;

   addr_t       col, col_cur;
   logic [15:0] col_rem, col_rem_cur, col_rem_sum;
   addr_t       row_base, row_base_cur, row_base_nxt;
   logic [15:0] row_rem, row_rem_cur, row_rem_sum, row_rem_nxt;

   pix_tag_t    tag_in, tag_out;
   pix_tag_t    tag_q [RD_LAT+1];
   rgb_t        unpacked;

   assign frame_start = (h_counter == 10'd0) && (v_counter == 10'd0);
   assign seq_bad     = have_prev &&
                        ((video_on && (h_counter != 10'd0) && (h_counter != prev_h + 10'd1)) ||
                         ((v_counter != prev_v) && (v_counter != prev_v + 10'd1) && (v_counter != 10'd0)));

   // Mode shadows take the live inputs on the frame-start pixel itself
   assign fmt_cur    = frame_start ? pix_fmt_e'(fmt) : fmt_sh;
   assign native_cur = frame_start ? native : native_sh;

   assign h_in_win = (h_counter >= X_LO) && (h_counter < X_HI);
   assign v_in_win = (v_counter >= Y_LO) && (v_counter < Y_HI);
   assign in_win   = native_cur ? (h_in_win && v_in_win) : 1'b1;
   assign active   = run && video_on;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_WAIT_FRAME;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      run       = 1'b0;
      case (state)
         ST_WAIT_FRAME: if (frame_start) begin
            state_nxt = ST_RUN;
            run       = 1'b1;
         end
         ST_RUN: if (seq_bad) state_nxt = ST_WAIT_FRAME;
                 else         run       = 1'b1;
         default: state_nxt = ST_WAIT_FRAME;
      endcase
   end

   // Column: DDA in stretch mode, plain counter from the window edge in native mode
   assign col_rem_sum = col_rem + IW_R;
   always_comb begin
      col_cur     = col;
      col_rem_cur = col_rem;
      if (native_cur) begin
         col_rem_cur = '0;
         col_cur     = (h_counter == X_LO) ? '0 : col + addr_t'(1);
      end else if (h_counter == 10'd0) begin
         col_cur     = '0;
         col_rem_cur = '0;
      end else if (col_rem_sum >= SW_R) begin
         col_cur     = col + addr_t'(1);
         col_rem_cur = col_rem_sum - SW_R;
      end else begin
         col_rem_cur = col_rem_sum;
      end
   end

   // Row base steps after the last active pixel of each line
   assign row_base_cur = frame_start ? '0 : row_base;
   assign row_rem_cur  = frame_start ? '0 : row_rem;
   assign row_rem_sum  = row_rem_cur + IH_R;
   always_comb begin
      row_base_nxt = row_base_cur;
      row_rem_nxt  = row_rem_cur;
      if (h_counter == H_LAST) begin
         if (native_cur) begin
            if (v_in_win) row_base_nxt = row_base_cur + IW_A;
         end else if (row_rem_sum >= SH_R) begin
            row_base_nxt = row_base_cur + IW_A;
            row_rem_nxt  = row_rem_sum - SH_R;
         end else begin
            row_rem_nxt  = row_rem_sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fmt_sh     <= GRAY8;
         native_sh  <= 1'b0;
         col        <= '0;
         col_rem    <= '0;
         row_base   <= '0;
         row_rem    <= '0;
         prev_h     <= '0;
         prev_v     <= '0;
         have_prev  <= 1'b0;
         seq_err    <= 1'b0;
         fb.rd_addr <= '0;
         fb.rd_en   <= 1'b0;
      end else begin
         fmt_sh     <= fmt_cur;
         native_sh  <= native_cur;
         col        <= col_cur;
         col_rem    <= col_rem_cur;
         row_base   <= row_base_nxt;
         row_rem    <= row_rem_nxt;
         prev_h     <= h_counter;
         prev_v     <= v_counter;
         have_prev  <= 1'b1;
         if (seq_bad) seq_err <= 1'b1;
         fb.rd_addr <= BASE_A + row_base_cur + col_cur;
         fb.rd_en   <= active && in_win;
      end
   end

   assign tag_in  = '{valid: active, inwin: in_win, fmt: fmt_cur};
   assign tag_out = tag_q[RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   pixel_unpack u_unpack (
      .fmt  (tag_out.fmt),
      .data (fb.rd_data),
      .rgb  (unpacked)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {VGA_R, VGA_G, VGA_B} <= '0;
         pix_valid             <= 1'b0;
      end else if (!tag_out.valid) begin
         {VGA_R, VGA_G, VGA_B} <= '0;
         pix_valid             <= 1'b0;
      end else begin
         {VGA_R, VGA_G, VGA_B} <= tag_out.inwin ? unpacked : rgb_t'(border_rgb);
         pix_valid             <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_pixel_scaler.sv
// Directed bench for vga_pixel_scaler: addressing in both modes, latency, unpack, faults.
module tb_vga_pixel_scaler;
   localparam int ADDR_W = 22;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic [9:0]  h_counter  = '0;
   logic [9:0]  v_counter  = '0;
   logic        video_on   = 1'b0;
   logic [1:0]  fmt        = 2'd0;
   logic        native     = 1'b0;
   logic [23:0] border_rgb = '0;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        pix_valid, seq_err;
   logic [31:0] mem_word   = '0;
   logic        use_word   = 1'b0;
   int          tests_run    = 0;
   int          tests_failed = 0;

   vga_pixel_scaler_if #(.ADDR_W(ADDR_W)) fb ();

   vga_pixel_scaler #(
      .IMG_W(300), .IMG_H(300), .SCREEN_W(640), .SCREEN_H(480),
      .ADDR_W(ADDR_W), .BASE_ADDR(0), .RD_LAT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .h_counter(h_counter), .v_counter(v_counter),
      .video_on(video_on), .fmt(fmt), .native(native), .border_rgb(border_rgb),
      .fb(fb), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .pix_valid(pix_valid), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   // One-cycle memory: either a fixed word or the address itself
   always_ff @(posedge clk) fb.rd_data <= use_word ? mem_word : 32'(fb.rd_addr);

   task automatic step(input int h, input int v, input logic von);
      h_counter = 10'(h);
      v_counter = 10'(v);
      video_on  = von;
      @(posedge clk);
      #1;
   endtask

   task automatic run_line(input int v, input int h0, input int h1, input logic von);
      for (int h = h0; h <= h1; h++) step(h, v, von);
   endtask

   // Frame start, then lines 0..tv-1 blanked with only h=0 and h=639 visited
   task automatic goto_line(input int tv);
      for (int v = 0; v < tv; v++) begin
         step(0, v, 1'b0);
         step(639, v, 1'b0);
      end
   endtask

   task automatic test_reset();
      step(0, 0, 1'b0);
      step(1, 0, 1'b0);
      tests_run++;
      if ({fb.rd_en, fb.rd_addr} !== 23'd0) begin
         tests_failed++; $display("FAIL reset_rd: got en=%0b addr=%0d expected 0/0", fb.rd_en, fb.rd_addr);
      end
      tests_run++;
      if ({pix_valid, seq_err, VGA_R, VGA_G, VGA_B} !== 26'd0) begin
         tests_failed++; $display("FAIL reset_out: got valid=%0b err=%0b rgb=%02h%02h%02h expected all 0", pix_valid, seq_err, VGA_R, VGA_G, VGA_B);
      end
      rst_n = 1'b1;
      run_line(5, 0, 9, 1'b1);
      tests_run++;
      if ({fb.rd_en, pix_valid} !== 2'b00) begin
         tests_failed++; $display("FAIL no_frame_yet: got en=%0b valid=%0b expected 0/0", fb.rd_en, pix_valid);
      end
   endtask

   task automatic test_stretch_gray();
      fmt = 2'd0; native = 1'b0; use_word = 1'b1; mem_word = 32'h0000_005A;
      goto_line(0);
      run_line(0, 0, 3, 1'b1);
      tests_run++;
      if ({fb.rd_en, fb.rd_addr} !== {1'b1, 22'd1}) begin
         tests_failed++; $display("FAIL stretch_h3: got en=%0b addr=%0d expected 1/1", fb.rd_en, fb.rd_addr);
      end
      run_line(0, 4, 5, 1'b1);
      tests_run++;
      if (fb.rd_addr !== 22'd2) begin
         tests_failed++; $display("FAIL stretch_h5: got addr=%0d expected 2", fb.rd_addr);
      end
      goto_line(479);
      run_line(479, 0, 639, 1'b1);
      tests_run++;
      if ({fb.rd_en, fb.rd_addr} !== {1'b1, 22'd89999}) begin
         tests_failed++; $display("FAIL stretch_last: got en=%0b addr=%0d expected 1/89999", fb.rd_en, fb.rd_addr);
      end
      run_line(479, 640, 641, 1'b0);
      tests_run++;
      if ({pix_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h5A5A5A}) begin
         tests_failed++; $display("FAIL gray8: got valid=%0b rgb=%02h%02h%02h expected 1 5A5A5A", pix_valid, VGA_R, VGA_G, VGA_B);
      end
      step(642, 479, 1'b0);
      tests_run++;
      if ({pix_valid, VGA_R, VGA_G, VGA_B} !== 25'd0) begin
         tests_failed++; $display("FAIL blank_after_line: got valid=%0b rgb=%02h%02h%02h expected 0 000000", pix_valid, VGA_R, VGA_G, VGA_B);
      end
   endtask

   task automatic test_latency();
      goto_line(0);
      run_line(0, 0, 9, 1'b0);
      step(10, 0, 1'b1);
      step(11, 0, 1'b1);
      tests_run++;
      if (pix_valid !== 1'b0) begin
         tests_failed++; $display("FAIL lat_rise_t2: got valid=%0b expected 0", pix_valid);
      end
      step(12, 0, 1'b1);
      tests_run++;
      if ({pix_valid, VGA_R} !== {1'b1, 8'h5A}) begin
         tests_failed++; $display("FAIL lat_rise_t3: got valid=%0b r=%02h expected 1 5A", pix_valid, VGA_R);
      end
      run_line(0, 13, 19, 1'b1);
      step(20, 0, 1'b0);
      step(21, 0, 1'b0);
      tests_run++;
      if (pix_valid !== 1'b1) begin
         tests_failed++; $display("FAIL lat_fall_t2: got valid=%0b expected 1", pix_valid);
      end
      step(22, 0, 1'b0);
      tests_run++;
      if ({pix_valid, VGA_R, VGA_G, VGA_B} !== 25'd0) begin
         tests_failed++; $display("FAIL lat_fall_t3: got valid=%0b rgb=%02h%02h%02h expected 0 000000", pix_valid, VGA_R, VGA_G, VGA_B);
      end
   endtask

   task automatic test_native();
      native = 1'b1; border_rgb = 24'h102030; fmt = 2'd0; mem_word = 32'h0000_0077;
      goto_line(90);
      run_line(90, 0, 169, 1'b1);
      tests_run++;
      if (fb.rd_en !== 1'b0) begin
         tests_failed++; $display("FAIL native_left_edge_en: got en=%0b expected 0", fb.rd_en);
      end
      step(170, 90, 1'b1);
      tests_run++;
      if ({fb.rd_en, fb.rd_addr} !== {1'b1, 22'd0}) begin
         tests_failed++; $display("FAIL native_first: got en=%0b addr=%0d expected 1/0", fb.rd_en, fb.rd_addr);
      end
      step(171, 90, 1'b1);
      tests_run++;
      if ({pix_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h102030}) begin
         tests_failed++; $display("FAIL native_border: got valid=%0b rgb=%02h%02h%02h expected 1 102030", pix_valid, VGA_R, VGA_G, VGA_B);
      end
      step(172, 90, 1'b1);
      tests_run++;
      if ({VGA_R, VGA_G, VGA_B} !== 24'h777777) begin
         tests_failed++; $display("FAIL native_image: got rgb=%02h%02h%02h expected 777777", VGA_R, VGA_G, VGA_B);
      end
      goto_line(389);
      run_line(389, 0, 469, 1'b1);
      tests_run++;
      if ({fb.rd_en, fb.rd_addr} !== {1'b1, 22'd89999}) begin
         tests_failed++; $display("FAIL native_last: got en=%0b addr=%0d expected 1/89999", fb.rd_en, fb.rd_addr);
      end
      step(470, 389, 1'b1);
      tests_run++;
      if (fb.rd_en !== 1'b0) begin
         tests_failed++; $display("FAIL native_right_edge_en: got en=%0b expected 0", fb.rd_en);
      end
      native = 1'b0;
   endtask

   task automatic test_unpack();
      logic [31:0] words [3];
      logic [23:0] exps  [3];
      int          h;
      words[0] = 32'h0000_F800; exps[0] = 24'hFF0000;
      words[1] = 32'h0000_07E0; exps[1] = 24'h00FF00;
      words[2] = 32'h0000_001F; exps[2] = 24'h0000FF;
      fmt = 2'd2;
      h = 0;
      for (int i = 0; i < 3; i++) begin
         mem_word = words[i];
         for (int k = 0; k < 3; k++) begin step(h, 0, 1'b1); h++; end
         tests_run++;
         if ({VGA_R, VGA_G, VGA_B} !== exps[i]) begin
            tests_failed++; $display("FAIL rgb565_%0d: got %02h%02h%02h expected %06h", i, VGA_R, VGA_G, VGA_B, exps[i]);
         end
      end
      fmt = 2'd1; mem_word = 32'h0012_3456;
      run_line(0, 0, 2, 1'b1);
      tests_run++;
      if ({VGA_R, VGA_G, VGA_B} !== 24'h123456) begin
         tests_failed++; $display("FAIL rgb888: got %02h%02h%02h expected 123456", VGA_R, VGA_G, VGA_B);
      end
      fmt = 2'd3;
      run_line(0, 0, 2, 1'b1);
      tests_run++;
      if ({pix_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h000000}) begin
         tests_failed++; $display("FAIL reserved_fmt: got valid=%0b rgb=%02h%02h%02h expected 1 000000", pix_valid, VGA_R, VGA_G, VGA_B);
      end
   endtask

   task automatic test_mode_change();
      fmt = 2'd0; mem_word = 32'h0012_3456;
      goto_line(100);
      run_line(100, 0, 9, 1'b1);
      fmt = 2'd1;
      run_line(100, 10, 19, 1'b1);
      tests_run++;
      if ({VGA_R, VGA_G, VGA_B} !== 24'h565656) begin
         tests_failed++; $display("FAIL midframe_fmt_held: got %02h%02h%02h expected 565656", VGA_R, VGA_G, VGA_B);
      end
      run_line(0, 0, 2, 1'b1);
      tests_run++;
      if ({VGA_R, VGA_G, VGA_B} !== 24'h123456) begin
         tests_failed++; $display("FAIL next_frame_fmt: got %02h%02h%02h expected 123456", VGA_R, VGA_G, VGA_B);
      end
   endtask

   task automatic test_seq_err();
      fmt = 2'd0; mem_word = 32'h0000_005A;
      goto_line(0);
      run_line(0, 0, 10, 1'b1);
      tests_run++;
      if (seq_err !== 1'b0) begin
         tests_failed++; $display("FAIL seq_err_clean: got %0b expected 0", seq_err);
      end
      step(20, 0, 1'b1);
      tests_run++;
      if (seq_err !== 1'b1) begin
         tests_failed++; $display("FAIL seq_err_set: got %0b expected 1", seq_err);
      end
      run_line(0, 21, 30, 1'b1);
      tests_run++;
      if ({seq_err, pix_valid, fb.rd_en} !== 3'b100) begin
         tests_failed++; $display("FAIL seq_err_black: got err=%0b valid=%0b en=%0b expected 1/0/0", seq_err, pix_valid, fb.rd_en);
      end
      run_line(0, 0, 2, 1'b1);
      tests_run++;
      if ({seq_err, pix_valid, VGA_R} !== {2'b11, 8'h5A}) begin
         tests_failed++; $display("FAIL seq_err_resync: got err=%0b valid=%0b r=%02h expected 1/1/5A", seq_err, pix_valid, VGA_R);
      end
   endtask

   task automatic test_reset_midframe();
      goto_line(100);
      run_line(100, 0, 200, 1'b1);
      tests_run++;
      if (pix_valid !== 1'b1) begin
         tests_failed++; $display("FAIL pre_reset_valid: got %0b expected 1", pix_valid);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({pix_valid, seq_err, VGA_R, VGA_G, VGA_B, fb.rd_en, fb.rd_addr} !== 49'd0) begin
         tests_failed++; $display("FAIL async_reset: got valid=%0b err=%0b rgb=%02h%02h%02h en=%0b addr=%0d expected all 0",
                                  pix_valid, seq_err, VGA_R, VGA_G, VGA_B, fb.rd_en, fb.rd_addr);
      end
      step(201, 100, 1'b1);
      step(202, 100, 1'b1);
      rst_n = 1'b1;
      run_line(100, 203, 220, 1'b1);
      tests_run++;
      if ({pix_valid, fb.rd_en, VGA_R, VGA_G, VGA_B} !== 26'd0) begin
         tests_failed++; $display("FAIL post_reset_black: got valid=%0b en=%0b rgb=%02h%02h%02h expected all 0", pix_valid, fb.rd_en, VGA_R, VGA_G, VGA_B);
      end
      run_line(0, 0, 2, 1'b1);
      tests_run++;
      if ({seq_err, pix_valid, VGA_R} !== {2'b01, 8'h5A}) begin
         tests_failed++; $display("FAIL post_reset_frame: got err=%0b valid=%0b r=%02h expected 0/1/5A", seq_err, pix_valid, VGA_R);
      end
   endtask

   initial begin
      test_reset();
      test_stretch_gray();
      test_latency();
      test_native();
      test_unpack();
      test_mode_change();
      test_seq_err();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
